// File: rtl/stream_mux_nx1_if.sv
// Stream bundle shared by the N:1 mux and its producers/consumer.
// The mux sits on the slave side and the environment on the master side.
interface stream_mux_nx1_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
);
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_chan;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/stream_mux_nx1.sv
// N:1 valid/ready stream multiplexer with one registered output stage.
// Channel choice is either an external select or round-robin among valid inputs.
module stream_mux_nx1 #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  stream_mux_nx1_if.slave bus
);

  logic [N-1:0]  grant;
  logic [SW-1:0] gidx;
  logic          found;
  logic [W-1:0]  mux_data;
  logic          load_en;
  logic          xfer;
  logic [SW-1:0] rr_ptr;

  assign load_en = !bus.out_valid || bus.out_ready;

  always_comb begin : grant_logic
    int unsigned idx;
    logic [SW-1:0] cand;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    if (!mode) begin
      // An out-of-range select simply yields no grant.
      if (int'(sel) < N) begin
        if (bus.in_valid[sel]) begin
          grant[sel] = 1'b1;
          gidx       = sel;
          found      = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < unsigned'(N); k++) begin
        idx = 32'(rr_ptr) + k;
        if (idx >= unsigned'(N)) idx = idx - unsigned'(N);
        cand = SW'(idx);
        if (!found && bus.in_valid[cand]) begin
          grant[cand] = 1'b1;
          gidx        = cand;
          found       = 1'b1;
        end
      end
    end
  end

  // Only the granted lane is selected, so idle lanes never reach the output.
  always_comb begin
    mux_data = '0;
    for (int unsigned i = 0; i < unsigned'(N); i++) begin
      if (grant[i]) mux_data = bus.in_data[i*W +: W];
    end
  end

  assign bus.in_ready = rst_n ? (grant & {N{load_en}}) : '0;
  assign xfer         = |(bus.in_valid & bus.in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_chan  <= '0;
      rr_ptr        <= '0;
    end else if (load_en) begin
      if (xfer) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= mux_data;
        bus.out_chan  <= gidx;
        if (mode) rr_ptr <= (gidx == SW'(N-1)) ? '0 : gidx + 1'b1;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule
